// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the Dcache req/wr/addrOK/dataOK port: posted write buffer
// draining into a line-organised store, and line reads returned after a fixed latency.
module dcache_mem_responder #(
    parameter int  INDEX_W    = 10,
    parameter int  OFFSET_W   = 2,
    parameter int  RD_LAT     = 2,
    parameter int  WR_LAT     = 1,
    parameter int  WBUF_DEPTH = 4,
    localparam int LINE_W     = 8 * (2 ** OFFSET_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dcache_mem_req,
    input  logic              dcache_mem_wr,
    input  logic [31:0]       dcache_mem_addr,
    input  logic [31:0]       dcache_mem_wdata,
    input  logic [3:0]        dcache_mem_wstrb,
    output logic              mem_dcache_addrOK,
    output logic              mem_dcache_dataOK,
    output logic [LINE_W-1:0] mem_dcache_rdata,
    output logic              wbuf_empty
);
    localparam int WORDS = 2 ** (OFFSET_W - 2);
    localparam int WA_W  = INDEX_W + OFFSET_W - 2;
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam int AGE_W = $clog2(WR_LAT + 1);

    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(WBUF_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [AGE_W-1:0] AGE_ZERO = AGE_W'(0);
    localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(WR_LAT - 1);
    localparam logic [CNT_W-1:0] RD_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] RD_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RD_INIT  = CNT_W'(RD_LAT - 1);
    localparam logic [WA_W-1:0]  SLOT_MSK = WA_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RD_RESP = 2'd2} state_t;

    state_t             state_r, state_next_s;
    logic [LINE_W-1:0]  store_r    [2**INDEX_W];
    logic [WA_W-1:0]    wb_waddr_r [WBUF_DEPTH];
    logic [31:0]        wb_data_r  [WBUF_DEPTH];
    logic [3:0]         wb_strb_r  [WBUF_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic [AGE_W-1:0]   age_r;
    logic [CNT_W-1:0]   rd_cnt_r;
    logic [INDEX_W-1:0] rd_idx_r;
    logic               dataok_r;
    logic [LINE_W-1:0]  rdata_r;

    logic               wr_accept_s, rd_accept_s, pop_s, read_now_s, unused_addr_s;
    logic [INDEX_W-1:0] req_idx_s, read_idx_s, commit_idx_s;
    logic [WA_W-1:0]    head_waddr_s, slot_s;
    logic [LINE_W-1:0]  line_mask_s, line_data_s, merged_s;

    assign req_idx_s     = dcache_mem_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign unused_addr_s = ^{dcache_mem_addr[31:OFFSET_W+INDEX_W], dcache_mem_addr[1:0]};
    assign head_waddr_s  = wb_waddr_r[rd_ptr_r];
    assign commit_idx_s  = head_waddr_s[WA_W-1:OFFSET_W-2];
    assign slot_s        = head_waddr_s & SLOT_MSK;
    assign pop_s         = (count_r != CNT_ZERO) && (age_r == AGE_LAST);

    assign mem_dcache_addrOK = wr_accept_s | rd_accept_s;
    assign mem_dcache_dataOK = dataok_r;
    assign mem_dcache_rdata  = rdata_r;
    assign wbuf_empty        = (count_r == CNT_ZERO);

    // Accept decision; reads wait for a fully drained buffer so they see every write.
    always_comb begin
        wr_accept_s = 1'b0;
        rd_accept_s = 1'b0;
        if (state_r == IDLE && dcache_mem_req) begin
            if (dcache_mem_wr) begin
                wr_accept_s = (count_r < DEPTH_C);
            end else begin
                rd_accept_s = (count_r == CNT_ZERO);
            end
        end else begin
            wr_accept_s = 1'b0;
            rd_accept_s = 1'b0;
        end
    end

    // Next state; the array is sampled in the cycle before the dataOK pulse.
    always_comb begin
        state_next_s = state_r;
        read_now_s   = 1'b0;
        read_idx_s   = rd_idx_r;
        case (state_r)
            IDLE: begin
                if (rd_accept_s && RD_LAT == 1) begin
                    state_next_s = RD_RESP;
                    read_now_s   = 1'b1;
                    read_idx_s   = req_idx_s;
                end else if (rd_accept_s) begin
                    state_next_s = RD_WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (rd_cnt_r == RD_ONE) begin
                    state_next_s = RD_RESP;
                    read_now_s   = 1'b1;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            RD_RESP: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Byte-masked merge of the head write into its target line.
    always_comb begin
        line_mask_s = {LINE_W{1'b0}};
        line_data_s = {LINE_W{1'b0}};
        for (int w = 0; w < WORDS; w++) begin
            line_data_s[w*32 +: 32] = wb_data_r[rd_ptr_r];
            for (int b = 0; b < 4; b++) begin
                if (slot_s == WA_W'(w) && wb_strb_r[rd_ptr_r][b]) begin
                    line_mask_s[w*32+b*8 +: 8] = 8'hFF;
                end else begin
                    line_mask_s[w*32+b*8 +: 8] = 8'h00;
                end
            end
        end
        merged_s = (store_r[commit_idx_s] & ~line_mask_s) | (line_data_s & line_mask_s);
    end

    // FSM state and read-path registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            rd_cnt_r <= RD_ZERO;
            rd_idx_r <= {INDEX_W{1'b0}};
            dataok_r <= 1'b0;
            rdata_r  <= {LINE_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            dataok_r <= read_now_s;
            if (read_now_s) begin
                rdata_r <= store_r[read_idx_s];
            end
            if (rd_accept_s) begin
                rd_cnt_r <= RD_INIT;
                rd_idx_r <= req_idx_s;
            end else if (state_r == RD_WAIT) begin
                rd_cnt_r <= rd_cnt_r - RD_ONE;
            end
        end
    end

    // Write-buffer pointers, occupancy and head age.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            age_r    <= AGE_ZERO;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (pop_s || count_r == CNT_ZERO) begin
                age_r <= AGE_ZERO;
            end else begin
                age_r <= age_r + AGE_ONE;
            end
        end
    end

    // Write-buffer entry storage.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            wb_waddr_r[wr_ptr_r] <= dcache_mem_addr[OFFSET_W+INDEX_W-1:2];
            wb_data_r[wr_ptr_r]  <= dcache_mem_wdata;
            wb_strb_r[wr_ptr_r]  <= dcache_mem_wstrb;
        end
    end

    // Commit the head write into the backing store.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            store_r[commit_idx_s] <= merged_s;
        end
    end
endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: three instances (default, WR_LAT=8, RD_LAT=3) checked
// each cycle against a queue-based model, plus hand-computed directed expectations.
module tb_dcache_mem_responder;
    localparam int NI = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [NI];
    logic        wr     [NI];
    logic [31:0] addr   [NI];
    logic [31:0] wdata  [NI];
    logic [3:0]  wstrb  [NI];
    logic        addrok [NI];
    logic        dataok [NI];
    logic [31:0] rdata  [NI];
    logic        wempty [NI];

    int n_checks = 0;
    int n_fail   = 0;
    int tcyc     = 0;

    wr_t         mq          [NI][$];
    int          mhead_since [NI];
    int          mdue        [NI];
    logic [9:0]  mridx       [NI];
    logic [31:0] mmem        [NI][1024];
    bit          mknown      [NI][1024];

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    dcache_mem_responder #(.INDEX_W(10), .OFFSET_W(2), .RD_LAT(2), .WR_LAT(1), .WBUF_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .dcache_mem_req(req[0]), .dcache_mem_wr(wr[0]),
        .dcache_mem_addr(addr[0]), .dcache_mem_wdata(wdata[0]), .dcache_mem_wstrb(wstrb[0]),
        .mem_dcache_addrOK(addrok[0]), .mem_dcache_dataOK(dataok[0]),
        .mem_dcache_rdata(rdata[0]), .wbuf_empty(wempty[0]));

    dcache_mem_responder #(.INDEX_W(10), .OFFSET_W(2), .RD_LAT(2), .WR_LAT(8), .WBUF_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .dcache_mem_req(req[1]), .dcache_mem_wr(wr[1]),
        .dcache_mem_addr(addr[1]), .dcache_mem_wdata(wdata[1]), .dcache_mem_wstrb(wstrb[1]),
        .mem_dcache_addrOK(addrok[1]), .mem_dcache_dataOK(dataok[1]),
        .mem_dcache_rdata(rdata[1]), .wbuf_empty(wempty[1]));

    dcache_mem_responder #(.INDEX_W(10), .OFFSET_W(2), .RD_LAT(3), .WR_LAT(1), .WBUF_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .dcache_mem_req(req[2]), .dcache_mem_wr(wr[2]),
        .dcache_mem_addr(addr[2]), .dcache_mem_wdata(wdata[2]), .dcache_mem_wstrb(wstrb[2]),
        .mem_dcache_addrOK(addrok[2]), .mem_dcache_dataOK(dataok[2]),
        .mem_dcache_rdata(rdata[2]), .wbuf_empty(wempty[2]));

    function automatic int rd_lat(input int i);
        return (i == 2) ? 3 : 2;
    endfunction

    function automatic int wr_lat(input int i);
        return (i == 1) ? 8 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no response within cycle budget (cycle %0d)", name, tcyc);
    endtask

    // Model: writes queue up and commit WR_LAT cycles after reaching the head; a read
    // is taken only with an empty queue and answers RD_LAT cycles later.
    always @(negedge clk) begin
        int  sz;
        bit  busy, e_aok, e_dok, popped;
        wr_t hd;
        for (int i = 0; i < NI; i++) begin
            sz = mq[i].size();
            if (rst) begin
                check($sformatf("i%0d rst addrOK", i), {31'd0, addrok[i]}, 32'd0);
                check($sformatf("i%0d rst dataOK", i), {31'd0, dataok[i]}, 32'd0);
                check($sformatf("i%0d rst wbuf_empty", i), {31'd0, wempty[i]}, 32'd1);
                check($sformatf("i%0d rst rdata", i), rdata[i], 32'd0);
                mq[i].delete();
                mdue[i] = -1;
            end else begin
                busy  = (mdue[i] >= 0) && (tcyc <= mdue[i]);
                e_aok = req[i] && !busy && (wr[i] ? (sz < 4) : (sz == 0));
                e_dok = (mdue[i] == tcyc);
                check($sformatf("i%0d addrOK", i), {31'd0, addrok[i]}, {31'd0, e_aok});
                check($sformatf("i%0d dataOK", i), {31'd0, dataok[i]}, {31'd0, e_dok});
                check($sformatf("i%0d wbuf_empty", i), {31'd0, wempty[i]}, {31'd0, sz == 0});
                if (e_dok) begin
                    if (mknown[i][mridx[i]]) begin
                        check($sformatf("i%0d rdata", i), rdata[i], mmem[i][mridx[i]]);
                    end
                    mdue[i] = -1;
                end
                popped = 1'b0;
                if (sz > 0 && tcyc == mhead_since[i] + wr_lat(i) - 1) begin
                    hd = mq[i][0];
                    for (int b = 0; b < 4; b++) begin
                        if (hd.s[b]) mmem[i][hd.a[11:2]][b*8 +: 8] = hd.d[b*8 +: 8];
                    end
                    if (hd.s == 4'hF) mknown[i][hd.a[11:2]] = 1'b1;
                    void'(mq[i].pop_front());
                    popped = 1'b1;
                end
                if (e_aok && wr[i]) begin
                    hd.a = addr[i];
                    hd.d = wdata[i];
                    hd.s = wstrb[i];
                    mq[i].push_back(hd);
                end
                if (popped || (e_aok && wr[i] && sz == 0)) mhead_since[i] = tcyc + 1;
                if (e_aok && !wr[i]) begin
                    mdue[i]  = tcyc + rd_lat(i);
                    mridx[i] = addr[i][11:2];
                end
            end
        end
    end

    task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int acc);
        int n;
        bit done;
        req[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; wdata[i] = d; wstrb[i] = s;
        n = 0; done = 1'b0; acc = -1;
        while (!done) begin
            @(negedge clk);
            if (addrok[i]) begin
                done = 1'b1;
                acc  = tcyc;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n >= 200) begin
                timeout($sformatf("i%0d write accept", i));
                done = 1'b1;
            end
        end
        req[i] = 1'b0; wr[i] = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [31:0] a, output logic [31:0] data,
                           output int acc, output int dok);
        int n;
        bit done;
        req[i] = 1'b1; wr[i] = 1'b0; addr[i] = a;
        n = 0; done = 1'b0; acc = -1; dok = -1; data = 32'd0;
        while (!done) begin
            @(negedge clk);
            if (addrok[i] && acc < 0) acc = tcyc;
            if (dataok[i]) begin
                dok  = tcyc;
                data = rdata[i];
                done = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            if (!done && n >= 200) begin
                timeout($sformatf("i%0d read dataOK", i));
                done = 1'b1;
            end
        end
        req[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          wa, ra, da;
        int          acc [5];
        logic [31:0] d;
        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wdata[i] = 32'd0; wstrb[i] = 4'd0;
            mdue[i] = -1; mhead_since[i] = 0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("reset rdata", rdata[0], 32'd0);
        check("reset wbuf_empty", {31'd0, wempty[0]}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Full-word write then read: read waits for the drain.
        do_write(0, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111, wa);
        do_read(0, 32'h0000_0040, d, ra, da);
        check("t1 read accept delay", ra - wa, 32'd2);
        check("t1 read latency", da - ra, 32'd2);
        check("t1 rdata", d, 32'hDEAD_BEEF);

        // Partial strobes merge; high address bits alias.
        do_write(0, 32'h0000_0040, 32'h1122_3344, 4'b0101, wa);
        do_read(0, 32'h8000_0040, d, ra, da);
        check("t2 merged rdata", d, 32'hDE22_BE44);

        // Zero strobes still occupy a slot but change nothing.
        do_write(0, 32'h0000_0040, 32'hFFFF_FFFF, 4'b0000, wa);
        @(negedge clk);
        check("t2 strb0 occupies slot", {31'd0, wempty[0]}, 32'd0);
        @(posedge clk); #1;
        do_read(0, 32'h0000_0040, d, ra, da);
        check("t2 strb0 rdata", d, 32'hDE22_BE44);

        // WR_LAT=8: fifth back-to-back write waits for the first commit.
        for (int k = 0; k < 5; k++) begin
            do_write(1, 32'h0000_0100 + 32'(k * 4), 32'h1000_0000 + 32'(k), 4'b1111, acc[k]);
        end
        check("t3 fourth write back-to-back", acc[3] - acc[0], 32'd3);
        check("t3 fifth write after commit", acc[4] - acc[0], 32'd9);
        for (int k = 0; k < 5; k++) begin
            do_read(1, 32'h0000_0100 + 32'(k * 4), d, ra, da);
            check($sformatf("t3 readback %0d", k), d, 32'h1000_0000 + 32'(k));
        end

        // RD_LAT=3 with req held through the response.
        do_write(2, 32'h0000_0200, 32'h0BAD_C0DE, 4'b1111, wa);
        do_read(2, 32'h0000_0200, d, ra, da);
        check("t4 read latency", da - ra, 32'd3);
        check("t4 rdata", d, 32'h0BAD_C0DE);
        idle(3);

        // Reset during RD_WAIT drops the read; store survives.
        do_write(0, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, wa);
        do_read(0, 32'h0000_0300, d, ra, da);
        check("t5 pre rdata", d, 32'hCAFE_F00D);
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0300;
        @(negedge clk);
        check("t5 read accepted", {31'd0, addrok[0]}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        check("t5 dataOK in reset", {31'd0, dataok[0]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        do_read(0, 32'h0000_0300, d, ra, da);
        check("t5 post-reset rdata", d, 32'hCAFE_F00D);

        // Reset discards buffered writes.
        do_write(1, 32'h0000_0500, 32'h0102_0304, 4'b1111, wa);
        do_write(1, 32'h0000_0504, 32'h0506_0708, 4'b1111, wa);
        do_read(1, 32'h0000_0504, d, ra, da);
        do_write(1, 32'h0000_0500, 32'hAAAA_AAAA, 4'b1111, wa);
        do_write(1, 32'h0000_0504, 32'hBBBB_BBBB, 4'b1111, wa);
        @(negedge clk);
        check("t6 buffer occupied", {31'd0, wempty[1]}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t6 empty in reset", {31'd0, wempty[1]}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        do_read(1, 32'h0000_0500, d, ra, da);
        check("t6 readback 0x500", d, 32'h0102_0304);
        do_read(1, 32'h0000_0504, d, ra, da);
        check("t6 readback 0x504", d, 32'h0506_0708);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
